// File: rtl/scene_sequencer.sv
// rtl/scene_sequencer.sv - game-flow scene controller with press edges, lockout, back key and choice cursor
// Optional idle timeout back to scene 1: define SCENE_SEQ_IDLE_TIMEOUT_EN.
module scene_sequencer #(
   parameter int NUM_SCENES   = 4,
   parameter int SCENE_W      = 4,
   parameter int CHOOSE_SCENE = 2,
   parameter int FIGHT_SCENE  = 3,
   parameter int NUM_CHOICES  = 4,
   parameter int CHOICE_W     = 2,
   parameter int LOCKOUT      = 16,
   parameter int IDLE_CYCLES  = 1000000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                key_C,
   input  logic                key_U,
   input  logic                key_D,
   input  logic                key_L,
   input  logic                key_R,
   input  logic                scene_done,
   output logic [SCENE_W-1:0]  scene_state,
   output logic                scene_enter,
   output logic [CHOICE_W-1:0] cursor,
   output logic [CHOICE_W-1:0] choice,
   output logic                locked
);

   localparam int LOCK_W = $clog2(LOCKOUT + 1);

   localparam logic [SCENE_W-1:0]  S_FIRST      = SCENE_W'(1);
   localparam logic [SCENE_W-1:0]  S_LAST       = SCENE_W'(NUM_SCENES);
   localparam logic [SCENE_W-1:0]  S_CHOOSE     = SCENE_W'(CHOOSE_SCENE);
   localparam logic [SCENE_W-1:0]  S_FIGHT      = SCENE_W'(FIGHT_SCENE);
   localparam logic [SCENE_W-1:0]  S_POST_FIGHT = (FIGHT_SCENE == NUM_SCENES) ?
                                                  SCENE_W'(1) : SCENE_W'(FIGHT_SCENE + 1);
   localparam logic [CHOICE_W-1:0] C_LAST       = CHOICE_W'(NUM_CHOICES - 1);
   localparam logic [LOCK_W-1:0]   LOCK_LOAD    = LOCK_W'(LOCKOUT);

   logic              key_c_q, key_u_q, key_d_q, key_l_q, key_r_q;
   logic              press_c, press_u, press_d, press_l, press_r;
   logic              acc_c, acc_u, acc_d, acc_l, any_acc;
   logic [LOCK_W-1:0] lock_cnt;
   logic [SCENE_W-1:0]  scene_nxt;
   logic [CHOICE_W-1:0] cursor_nxt, choice_nxt;
   logic              scene_change;
   logic              idle_fire;
   logic              unused_keys;

   assign press_c = key_C & ~key_c_q;
   assign press_u = key_U & ~key_u_q;
   assign press_d = key_D & ~key_d_q;
   assign press_l = key_L & ~key_l_q;
   assign press_r = key_R & ~key_r_q;

   assign locked  = (lock_cnt != '0);

   // Presses seen while locked are simply dropped; the key history still advances.
   assign acc_c   = press_c & ~locked;
   assign acc_u   = press_u & ~locked;
   assign acc_d   = press_d & ~locked;
   assign acc_l   = press_l & ~locked;
   assign any_acc = acc_c | acc_u | acc_d | acc_l;

   assign unused_keys = press_r;

`ifdef SCENE_SEQ_IDLE_TIMEOUT_EN
   localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

   logic [IDLE_W-1:0] idle_cnt;
   logic              idle_scene;

   assign idle_scene = (scene_state != S_FIRST) && (scene_state != S_FIGHT);
   assign idle_fire  = idle_scene && (idle_cnt == IDLE_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idle_cnt <= '0;
      end else if (!idle_scene || scene_change || any_acc) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + IDLE_W'(1);
      end
   end
`else
   logic unused_idle;
   assign idle_fire   = 1'b0;
   assign unused_idle = (IDLE_CYCLES > 0);
`endif

   always_comb begin
      scene_nxt  = scene_state;
      cursor_nxt = cursor;
      choice_nxt = choice;
      if (scene_state < S_FIRST || scene_state > S_LAST) begin
         scene_nxt = S_FIRST;
      end else if (scene_state == S_FIGHT) begin
         // The fight scene listens only to scene_done, and does so even when locked.
         if (scene_done) begin
            scene_nxt = S_POST_FIGHT;
         end
      end else if (idle_fire) begin
         scene_nxt = S_FIRST;
      end else if (acc_c) begin
         scene_nxt = (scene_state == S_LAST) ? S_FIRST : scene_state + SCENE_W'(1);
         if (scene_state == S_CHOOSE) begin
            choice_nxt = cursor;
         end
      end else if (acc_l && scene_state > S_FIRST && scene_state < S_FIGHT) begin
         scene_nxt = scene_state - SCENE_W'(1);
      end else if (scene_state == S_CHOOSE) begin
         if (acc_d && !acc_u) begin
            cursor_nxt = (cursor == C_LAST) ? '0 : cursor + CHOICE_W'(1);
         end else if (acc_u && !acc_d) begin
            cursor_nxt = (cursor == '0) ? C_LAST : cursor - CHOICE_W'(1);
         end
      end
      // Re-entering the choose scene re-shows the last confirmed item.
      if (scene_nxt == S_CHOOSE && scene_state != S_CHOOSE) begin
         cursor_nxt = choice_nxt;
      end
   end

   assign scene_change = (scene_nxt != scene_state);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key_c_q     <= 1'b0;
         key_u_q     <= 1'b0;
         key_d_q     <= 1'b0;
         key_l_q     <= 1'b0;
         key_r_q     <= 1'b0;
         scene_state <= S_FIRST;
         scene_enter <= 1'b0;
         cursor      <= '0;
         choice      <= '0;
         lock_cnt    <= '0;
      end else begin
         key_c_q     <= key_C;
         key_u_q     <= key_U;
         key_d_q     <= key_D;
         key_l_q     <= key_L;
         key_r_q     <= key_R;
         scene_state <= scene_nxt;
         scene_enter <= scene_change;
         cursor      <= cursor_nxt;
         choice      <= choice_nxt;
         if (scene_change) begin
            lock_cnt <= LOCK_LOAD;
         end else if (locked) begin
            lock_cnt <= lock_cnt - LOCK_W'(1);
         end
      end
   end

endmodule

// File: doc/scene_sequencer.md
Name: scene_sequencer

Overview:
- Parametrised top-level scene controller for the game flow: start -> choose -> ... -> fight -> ... -> wrap to start. Scene count and the positions of the choose and fight scenes are set by parameters.
- Adds behaviour the flat scene FSM lacks:
  - key rising-edge detection, so one press equals one step;
  - a post-transition lockout window;
  - a back key for the pre-fight scenes;
  - a wrap-around selection cursor in the choose scene, with the selection latched on confirm;
  - a scene-entry pulse for the downstream renderers.
- Sits between the debounced key inputs and the per-scene display/fight logic.

Parameters:
- NUM_SCENES, 4, number of scenes. Scenes are encoded 1..NUM_SCENES. Must be >= 3.
- SCENE_W, 4, width of scene_state. Must hold NUM_SCENES.
- CHOOSE_SCENE, 2, scene index hosting the selection cursor.
- FIGHT_SCENE, 3, scene index that leaves only on scene_done. Must be greater than CHOOSE_SCENE.
- NUM_CHOICES, 4, number of selectable items. Must be >= 2.
- CHOICE_W, 2, width of cursor/choice.
- LOCKOUT, 16, cycles during which key presses are discarded after any scene change. Must be >= 1.
- IDLE_CYCLES, 1000000, idle timeout length. Used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- key_C  in  1  confirm key (level, debounced).
- key_U  in  1  cursor up.
- key_D  in  1  cursor down.
- key_L  in  1  back.
- key_R  in  1  reserved. Edge-registered, no effect.
- scene_done  in  1  fight-complete request. Level-sensitive.
- scene_state  out  SCENE_W  current scene.
- scene_enter  out  1  one-cycle pulse on the first cycle of a new scene.
- cursor  out  CHOICE_W  live selection index.
- choice  out  CHOICE_W  selection latched on confirm in CHOOSE_SCENE.
- locked  out  1  high while the lockout counter is non-zero.

Behaviour:
- Reset (reset=0, asynchronous):
  - scene_state=1, cursor=0, choice=0, scene_enter=0, locked=0.
  - Lockout counter and all key-history registers cleared.
  - Reset mid-transition or mid-lockout discards everything.
  - No scene_enter pulse after reset release.
- Press detection:
  - press_X = key_X & ~key_X_q, where key_X_q is the key value registered on the previous edge.
  - A key held low through reset and raised afterwards counts as a press.
  - Presses are discarded, not queued, while locked=1.
- Scene transitions, evaluated on each clk edge with the unlocked presses. First match wins:
  1. scene_state outside 1..NUM_SCENES -> 1.
  2. scene_state == FIGHT_SCENE: scene_done=1 -> FIGHT_SCENE+1, or 1 if FIGHT_SCENE == NUM_SCENES. scene_done ignores lockout. All keys are ignored in this scene.
  3. press_C -> scene+1, wrapping NUM_SCENES -> 1. In CHOOSE_SCENE, choice <= cursor on the same edge.
  4. press_L with 1 < scene < FIGHT_SCENE -> scene-1. In any other scene press_L is ignored.
  5. Otherwise hold.
- Simultaneous press_C and press_L: C wins.
- scene_done outside FIGHT_SCENE has no effect.
- Latency: the state changes on the same edge at which the press is detected.
- scene_enter = 1 for exactly the one cycle following a state change, registered. Back-to-back changes are impossible because of lockout, except a fight exit, which is itself a change.
- Lockout:
  - Any state change loads the counter with LOCKOUT. It decrements each cycle to 0.
  - locked = (counter != 0).
  - A press arriving exactly when the counter reads 0 is accepted.
- Cursor:
  - Active only in CHOOSE_SCENE when unlocked.
  - press_D: cursor+1, wrapping NUM_CHOICES-1 -> 0.
  - press_U: cursor-1, wrapping 0 -> NUM_CHOICES-1.
  - press_U and press_D together: no change.
  - press_C together with press_U or press_D: the confirm uses the pre-move cursor and the move is dropped.
  - On entry to CHOOSE_SCENE the cursor is loaded from choice, so the last confirmed item is re-shown after a back step.
- choice holds its value outside CHOOSE_SCENE until the next confirm or reset.

Optional Feature:
- Macro: SCENE_SEQ_IDLE_TIMEOUT_EN.
- Defined:
  - An idle counter runs in every scene except 1 and FIGHT_SCENE.
  - It is cleared by any accepted press or any state change.
  - On reaching IDLE_CYCLES-1 the block forces scene_state=1 on the next edge. This transition pulses scene_enter and loads lockout. The cursor and choice are left unchanged.
- Undefined: no idle counter is built, IDLE_CYCLES is unused, and scenes hold indefinitely.

Test Plan:
- Default params, release reset, pulse key_C for 1 cycle -> scene_state 1->2 on that edge, scene_enter high for one cycle, locked high for 16 cycles.
- Hold key_C high for 50 cycles in scene 1 -> exactly one step, to 2. A second pulse at lockout cycle 5 is ignored; a pulse after locked falls moves to 3.
- In scene 2 from cursor=0: press_U -> 3, press_D -> 0, U+D together -> 0, then key_C -> choice=0 and scene 3. Repeat with cursor=3 and confirm -> choice=3.
- In scene 3: key_C and key_L pulses give no change; scene_done=1 -> scene 4 with an enter pulse. key_C in scene 4 -> scene 1. key_L in scene 1 -> no change.
- In scene 2 with choice=2: key_L -> scene 1; key_C after lockout -> scene 2 with cursor=2. Assert reset mid-lockout -> all outputs at reset values immediately, without waiting for a clk edge.
- With SCENE_SEQ_IDLE_TIMEOUT_EN and IDLE_CYCLES=100: idle in scene 2 -> scene 1 after 100 cycles with scene_enter. With the macro undefined -> still in scene 2 at 10000 cycles.
